// File: rtl/imem_port_arbiter.sv
// Two-port (fetch/debug) arbiter for the single combinational read port of the instruction ROM.
// Fetch has priority; a saturating wait counter forces a debug grant after DBG_MAX_WAIT cycles.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_BYTES    = 8192,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [31:0]       f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [12:0]       mem_addr,
  input  logic [31:0]       mem_data
);

  localparam int unsigned       WORD_W    = $clog2(MEM_BYTES) - 2;
  localparam int unsigned       WAIT_W    = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(DBG_MAX_WAIT);

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a >= MEM_LIMIT);
  endfunction

  function automatic logic [31:0] rsp_word(input logic err, input logic [31:0] d);
    return err ? 32'h0 : d;
  endfunction

  logic              f_rsp_valid_q, f_rsp_valid_d;
  logic [31:0]       f_rsp_data_q, f_rsp_data_d;
  logic              f_rsp_err_q, f_rsp_err_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]       d_rsp_data_q, d_rsp_data_d;
  logic              d_rsp_err_q, d_rsp_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              f_free, d_free, f_elig, d_elig, f_grant, d_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;
  logic [31:0]       sel_word;

  always_comb begin
    f_free   = !f_rsp_valid_q || f_rsp_ready;
    d_free   = !d_rsp_valid_q || d_rsp_ready;
    f_elig   = rst_n && f_req_valid && f_free;
    d_elig   = rst_n && d_req_valid && d_free;
    // Debug only overrides a competing fetch once it has waited the full budget
    d_grant  = d_elig && (!f_elig || (wait_cnt_q == WAIT_MAX));
    f_grant  = f_elig && !d_grant;
    sel_addr = d_grant ? d_req_addr : f_req_addr;
    sel_err  = addr_err(sel_addr);
    sel_word = rsp_word(sel_err, mem_data);
    mem_addr = (f_grant || d_grant) ? 13'(sel_addr[WORD_W+1:2]) : 13'h0;

    f_rsp_valid_d = f_rsp_valid_q && !f_rsp_ready;
    f_rsp_data_d  = f_rsp_data_q;
    f_rsp_err_d   = f_rsp_err_q;
    if (f_grant) begin
      f_rsp_valid_d = 1'b1;
      f_rsp_data_d  = sel_word;
      f_rsp_err_d   = sel_err;
    end

    d_rsp_valid_d = d_rsp_valid_q && !d_rsp_ready;
    d_rsp_data_d  = d_rsp_data_q;
    d_rsp_err_d   = d_rsp_err_q;
    if (d_grant) begin
      d_rsp_valid_d = 1'b1;
      d_rsp_data_d  = sel_word;
      d_rsp_err_d   = sel_err;
    end

    wait_cnt_d = wait_cnt_q;
    if (!d_req_valid || d_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rsp_valid_q <= 1'b0;
      f_rsp_data_q  <= 32'h0;
      f_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= 32'h0;
      d_rsp_err_q   <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      f_rsp_valid_q <= f_rsp_valid_d;
      f_rsp_data_q  <= f_rsp_data_d;
      f_rsp_err_q   <= f_rsp_err_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
      d_rsp_err_q   <= d_rsp_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign f_req_ready = f_grant;
  assign d_req_ready = d_grant;
  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rsp_data  = f_rsp_data_q;
  assign f_rsp_err   = f_rsp_err_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign d_rsp_err   = d_rsp_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter; the ROM returns {16'hC0DE, 3'b000, word_index}.
module tb_imem_port_arbiter;

  logic        clk, rst_n;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_req_addr, f_rsp_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] d_req_addr, d_rsp_data;
  logic [12:0] mem_addr;
  logic [31:0] mem_data;

  int checks = 0;
  int failures = 0;

  imem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(8192), .DBG_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  assign mem_data = {16'hC0DE, 3'b000, mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    f_req_valid = 0; f_req_addr = 0; f_rsp_ready = 1;
    d_req_valid = 0; d_req_addr = 0; d_rsp_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    f_req_valid = 1; d_req_valid = 1;
    #2;
    checks++;
    if ({f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err});
    end
    checks++;
    if ({f_rsp_data, d_rsp_data} !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", f_rsp_data, d_rsp_data);
    end
    checks++;
    if ({f_req_ready, d_req_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {f_req_ready, d_req_ready});
    end
    @(negedge clk); @(negedge clk);
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f_req_valid = 1; f_req_addr = 32'(4 * i); f_rsp_ready = 1;
      #1;
      checks++;
      if (f_req_ready !== 1'b1 || mem_addr !== 13'(i)) begin
        failures++; $display("FAIL stream_ready[%0d] got=%b/%h exp=1/%h", i, f_req_ready, mem_addr, 13'(i));
      end
      @(posedge clk); #1;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_err !== 1'b0 || f_rsp_data !== (32'hC0DE0000 + 32'(i))) begin
        failures++; $display("FAIL stream_rsp[%0d] got=%b/%b/%h exp=1/0/%h", i, f_rsp_valid, f_rsp_err,
                             f_rsp_data, 32'hC0DE0000 + 32'(i));
      end
    end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++;
    if (f_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL stream_drain got=%b exp=0", f_rsp_valid);
    end
  endtask

  task automatic test_priority();
    logic [5:0] exp_d;
    exp_d = 6'b010000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      f_req_valid = 1; f_req_addr = 32'h10; d_req_valid = 1; d_req_addr = 32'h20;
      #1;
      checks++;
      if (f_req_ready !== !exp_d[c] || d_req_ready !== exp_d[c]) begin
        failures++; $display("FAIL prio_cycle%0d got f=%b d=%b exp f=%b d=%b", c, f_req_ready, d_req_ready,
                             !exp_d[c], exp_d[c]);
      end
      if (c == 5) begin
        checks++;
        if (dut.wait_cnt_q !== 3'd0) begin
          failures++; $display("FAIL prio_wait_clear got=%0d exp=0", dut.wait_cnt_q);
        end
      end
      if (c == 4) begin
        @(posedge clk); #1;
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hC0DE0008) begin
          failures++; $display("FAIL prio_d_rsp got=%b/%h exp=1/c0de0008", d_rsp_valid, d_rsp_data);
        end
      end
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_errors();
    @(negedge clk); f_req_valid = 1; f_req_addr = 32'h2;
    @(posedge clk); #1;
    checks++;
    if (f_rsp_err !== 1'b1 || f_rsp_data !== 32'h0) begin
      failures++; $display("FAIL err_misalign got=%b/%h exp=1/0", f_rsp_err, f_rsp_data);
    end
    @(negedge clk); f_req_addr = 32'h2000;
    @(posedge clk); #1;
    checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_err !== 1'b1 || f_rsp_data !== 32'h0) begin
      failures++; $display("FAIL err_range got=%b/%b/%h exp=1/1/0", f_rsp_valid, f_rsp_err, f_rsp_data);
    end
    @(negedge clk); f_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h1FFC;
    @(posedge clk); #1;
    checks++;
    if (d_rsp_err !== 1'b0 || d_rsp_data !== 32'hC0DE07FF) begin
      failures++; $display("FAIL err_last_word got=%b/%h exp=0/c0de07ff", d_rsp_err, d_rsp_data);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_debug_stall();
    @(negedge clk); d_req_valid = 1; d_req_addr = 32'h40; d_rsp_ready = 0;
    #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      failures++; $display("FAIL stall_accept got=%b exp=1", d_req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      d_req_addr = 32'h40 + 32'(4 * k);
      f_req_valid = 1; f_req_addr = 32'(4 * k); f_rsp_ready = 1;
      #1;
      checks++;
      if (d_req_ready !== 1'b0 || f_req_ready !== 1'b1) begin
        failures++; $display("FAIL stall_ready[%0d] got d=%b f=%b exp d=0 f=1", k, d_req_ready, f_req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hC0DE0010 ||
          f_rsp_data !== (32'hC0DE0000 + 32'(k))) begin
        failures++; $display("FAIL stall_hold[%0d] got d=%b/%h f=%h exp d=1/c0de0010 f=%h", k, d_rsp_valid,
                             d_rsp_data, f_rsp_data, 32'hC0DE0000 + 32'(k));
      end
    end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++;
    if (d_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL stall_drain got=%b exp=0", d_rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); f_req_valid = 1; f_req_addr = 32'h8; f_rsp_ready = 0;
    @(posedge clk); #1;
    @(negedge clk); f_req_addr = 32'hC;
    #1;
    checks++;
    if (f_req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_blocked got=%b exp=0", f_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hC0DE0002) begin
      failures++; $display("FAIL b2b_hold got=%b/%h exp=1/c0de0002", f_rsp_valid, f_rsp_data);
    end
    @(negedge clk); f_rsp_ready = 1;
    #1;
    checks++;
    if (f_req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready got=%b exp=1", f_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hC0DE0003) begin
      failures++; $display("FAIL b2b_next got=%b/%h exp=1/c0de0003", f_rsp_valid, f_rsp_data);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk); f_req_valid = 1; f_req_addr = 32'h0; f_rsp_ready = 0;
    @(negedge clk); f_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h4; d_rsp_ready = 0;
    @(negedge clk); d_req_valid = 0;
    #1;
    checks++;
    if ({f_rsp_valid, d_rsp_valid} !== 2'b11) begin
      failures++; $display("FAIL midop_full got=%b exp=11", {f_rsp_valid, d_rsp_valid});
    end
    #2; rst_n = 0; f_req_valid = 1; f_req_addr = 32'h10;
    #1;
    checks++;
    if ({f_rsp_valid, d_rsp_valid, f_req_ready} !== 3'b000) begin
      failures++; $display("FAIL midop_clear got=%b exp=000", {f_rsp_valid, d_rsp_valid, f_req_ready});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1; f_rsp_ready = 1; d_rsp_ready = 1;
    #1;
    checks++;
    if (f_req_ready !== 1'b1) begin
      failures++; $display("FAIL midop_first_grant got=%b exp=1", f_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (f_rsp_valid !== 1'b1 || f_rsp_err !== 1'b0 || f_rsp_data !== 32'hC0DE0004 || d_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midop_rsp got=%b/%b/%h d=%b exp=1/0/c0de0004 d=0", f_rsp_valid, f_rsp_err,
                           f_rsp_data, d_rsp_valid);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_priority();
    test_errors();
    test_debug_stall();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
